// File: rtl/acq_sequencer.sv
// acq_sequencer: command-byte driven acquisition sequencer.
// Parses opcode bytes from a mask_bit/data handshake and steps through
// IDLE -> CLEAR -> ARM -> RUN -> HALT to drive the timetag clear,
// the detector start/stop pulses and the laser pulse sequencer enable.
// Optional feature macro: ACQ_OVERFLOW_STOP_EN
//   defined   : fifo_full during RUN ends the acquisition on the next cycle
//   undefined : fifo_full only raises the sticky overflow flag
module acq_sequencer #(
  parameter int DUR_W      = 32,
  parameter int CLR_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mask_bit,
  input  logic [7:0] data,
  output logic       data_ack,
  input  logic       fifo_full,
  output logic       reset_counter,
  output logic       start_det,
  output logic       stop_det,
  output logic       seq_operate,
  output logic       running,
  output logic       overflow,
  output logic       done
);

  // Duration bytes per SET_DUR and the width of the byte index into it.
  localparam int NB    = DUR_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  // Last value of the CLEAR cycle counter before moving on to ARM.
  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);

  localparam logic [7:0] OP_START       = 8'h01;
  localparam logic [7:0] OP_STOP        = 8'h02;
  localparam logic [7:0] OP_SET_DUR     = 8'h03;
  localparam logic [7:0] OP_START_TIMED = 8'h04;
  localparam logic [7:0] OP_CLR_OVF     = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_RUN,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         clrCnt_q, clrCnt_d;
  logic               dataAck_q, dataAck_d;
  logic               durActive_q, durActive_d;
  logic [IDX_W-1:0]   durIdx_q, durIdx_d;
  logic [DUR_W-1:0]   durShadow_q, durShadow_d;
  logic [DUR_W-1:0]   durLive_q, durLive_d;
  logic               timedReq_q, timedReq_d;
  logic               timed_q, timed_d;
  logic [DUR_W-1:0]   timer_q, timer_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  logic byteTake;
  logic opByte;
  logic cmdStart;
  logic cmdStop;
  logic cmdStartTimed;
  logic cmdClrOvf;
  logic timerExpire;
  logic runningNow;
  logic ovfStop;

  // A byte is consumed whenever one is offered outside the ack cycle; bytes
  // that belong to a SET_DUR payload are never decoded as opcodes.
  assign byteTake      = mask_bit && !dataAck_q;
  assign opByte        = byteTake && !durActive_q;
  assign cmdStart      = opByte && (data == OP_START);
  assign cmdStop       = opByte && (data == OP_STOP);
  assign cmdStartTimed = opByte && (data == OP_START_TIMED);
  assign cmdClrOvf     = opByte && (data == OP_CLR_OVF);

  assign timerExpire = timed_q && (timer_q == DUR_W'(1));
  assign runningNow  = (state_q == S_CLEAR) || (state_q == S_ARM) || (state_q == S_RUN);

`ifdef ACQ_OVERFLOW_STOP_EN
  assign ovfStop = fifo_full;
`else
  assign ovfStop = 1'b0;
`endif

  // SET_DUR payload capture: bytes land LSB first in the shadow register.
  always_comb begin
    durActive_d = durActive_q;
    durIdx_d    = durIdx_q;
    durShadow_d = durShadow_q;
    if (byteTake) begin
      if (durActive_q) begin
        for (int b = 0; b < NB; b++) begin
          if (durIdx_q == IDX_W'(b)) begin
            durShadow_d[b*8 +: 8] = data;
          end
        end
        if (durIdx_q == IDX_W'(NB - 1)) begin
          durActive_d = 1'b0;
          durIdx_d    = '0;
        end else begin
          durIdx_d = durIdx_q + IDX_W'(1);
        end
      end else if (data == OP_SET_DUR) begin
        durActive_d = 1'b1;
        durIdx_d    = '0;
      end
    end
  end

  // Sequencer next state, CLEAR length counter and RUN down-counter.
  always_comb begin
    state_d    = state_q;
    clrCnt_d   = clrCnt_q;
    timedReq_d = timedReq_q;
    durLive_d  = durLive_q;
    timed_d    = timed_q;
    timer_d    = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmdStart || cmdStartTimed) begin
          state_d    = S_CLEAR;
          clrCnt_d   = '0;
          timedReq_d = cmdStartTimed;
          if (cmdStartTimed) begin
            durLive_d = durShadow_q;
          end
        end
      end
      S_CLEAR: begin
        if (clrCnt_q == CLR_LAST) begin
          state_d = S_ARM;
        end else begin
          clrCnt_d = clrCnt_q + 4'd1;
        end
      end
      S_ARM: begin
        state_d = S_RUN;
        timer_d = durLive_q;
        timed_d = timedReq_q && (durLive_q != '0);
      end
      S_RUN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - DUR_W'(1);
        end
        if (cmdStop || timerExpire || ovfStop) begin
          state_d = S_HALT;
          timed_d = 1'b0;
        end
      end
      S_HALT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky overflow: a new fifo_full while running wins over CLR_OVF.
  always_comb begin
    overflow_d = overflow_q;
    if (fifo_full && runningNow) begin
      overflow_d = 1'b1;
    end else if (cmdClrOvf) begin
      overflow_d = 1'b0;
    end
  end

  // Single-cycle pulses: byte acknowledge and completion after HALT.
  always_comb begin
    dataAck_d = byteTake;
    done_d    = (state_q == S_HALT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clrCnt_q    <= '0;
      dataAck_q   <= 1'b0;
      durActive_q <= 1'b0;
      durIdx_q    <= '0;
      durShadow_q <= '0;
      durLive_q   <= '0;
      timedReq_q  <= 1'b0;
      timed_q     <= 1'b0;
      timer_q     <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrCnt_q    <= clrCnt_d;
      dataAck_q   <= dataAck_d;
      durActive_q <= durActive_d;
      durIdx_q    <= durIdx_d;
      durShadow_q <= durShadow_d;
      durLive_q   <= durLive_d;
      timedReq_q  <= timedReq_d;
      timed_q     <= timed_d;
      timer_q     <= timer_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  assign data_ack      = dataAck_q;
  assign reset_counter = (state_q == S_CLEAR);
  assign start_det     = (state_q == S_ARM);
  assign stop_det      = (state_q == S_HALT);
  assign seq_operate   = (state_q == S_ARM) || (state_q == S_RUN);
  assign running       = runningNow;
  assign overflow      = overflow_q;
  assign done          = done_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed, table-driven bench for acq_sequencer.
module tb_acq_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mask_bit;
  logic [7:0] data;
  logic       data_ack;
  logic       fifo_full;
  logic       reset_counter;
  logic       start_det;
  logic       stop_det;
  logic       seq_operate;
  logic       running;
  logic       overflow;
  logic       done;

  int total = 0;
  int bad = 0;
  int bytesSent = 0;

  int rcCnt = 0;
  int startCnt = 0;
  int stopCnt = 0;
  int doneCnt = 0;
  int runCnt = 0;
  int ackCnt = 0;

  // One table row: optional byte, optional one-cycle fifo_full pulse,
  // idle cycles, then expected {running, seq_operate, reset_counter,
  // start_det, stop_det, done, overflow}.
  typedef struct {
    logic       sendIt;
    logic [7:0] byteVal;
    logic       pulseFull;
    int         waitCycles;
    logic [6:0] expOut;
  } vec_t;

  vec_t vecs[13];

  acq_sequencer #(.DUR_W(32), .CLR_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .mask_bit(mask_bit),
    .data(data),
    .data_ack(data_ack),
    .fifo_full(fifo_full),
    .reset_counter(reset_counter),
    .start_det(start_det),
    .stop_det(stop_det),
    .seq_operate(seq_operate),
    .running(running),
    .overflow(overflow),
    .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Pulse and cycle counters sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_counter) rcCnt++;
    if (start_det) startCnt++;
    if (stop_det) stopCnt++;
    if (done) doneCnt++;
    if (running && seq_operate && !start_det) runCnt++;
    if (data_ack) ackCnt++;
  end

  function automatic int outVec();
    return int'({running, seq_operate, reset_counter, start_det, stop_det, done, overflow});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0b%0b) expected %0d (0b%0b)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    mask_bit = 1'b1;
    data = b;
    for (int i = 0; i < 8; i++) begin
      step();
      if (data_ack) begin
        seen = 1'b1;
        break;
      end
    end
    mask_bit = 1'b0;
    bytesSent++;
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL ack byte 0x%02h: got no data_ack expected data_ack within 8 cycles", b);
    end
  endtask

  task automatic waitDone(input string name, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL %s: got no done pulse expected done within %0d cycles", name, limit);
    end
    step();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.sendIt) sendByte(v.byteVal);
    if (v.pulseFull) begin
      fifo_full = 1'b1;
      step();
      fifo_full = 1'b0;
    end
    for (int i = 0; i < v.waitCycles; i++) step();
  endtask

  task automatic runTimed(input int dur, input string name);
    int rc0, st0, sp0, dn0, rn0;
    rc0 = rcCnt; st0 = startCnt; sp0 = stopCnt; dn0 = doneCnt; rn0 = runCnt;
    sendByte(8'h03);
    for (int k = 0; k < 4; k++) sendByte(8'(dur >> (8 * k)));
    sendByte(8'h04);
    waitDone({name, " done"}, 60);
    checkOutput({name, " done width"}, int'(done), 0);
    checkOutput({name, " clear cycles"}, rcCnt - rc0, 2);
    checkOutput({name, " start pulses"}, startCnt - st0, 1);
    checkOutput({name, " run cycles"}, runCnt - rn0, dur);
    checkOutput({name, " stop pulses"}, stopCnt - sp0, 1);
    checkOutput({name, " done pulses"}, doneCnt - dn0, 1);
    checkOutput({name, " running end"}, int'({running, seq_operate}), 0);
  endtask

  initial begin
    int sp0, dn0, rn0;

    vecs[0]  = '{1'b1, 8'h01, 1'b0, 0, 7'b1010000};
    vecs[1]  = '{1'b1, 8'h02, 1'b0, 0, 7'b1101000};
    vecs[2]  = '{1'b1, 8'h7F, 1'b0, 0, 7'b1100000};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 5, 7'b1100000};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 0, 7'b0000100};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1, 7'b0000010};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 0, 7'b0000000};
    vecs[7]  = '{1'b1, 8'hFF, 1'b0, 0, 7'b0000000};
    vecs[8]  = '{1'b1, 8'h05, 1'b0, 0, 7'b0000000};
    vecs[9]  = '{1'b1, 8'h01, 1'b0, 2, 7'b1101000};
    vecs[10] = '{1'b1, 8'h01, 1'b0, 0, 7'b1100000};
    vecs[11] = '{1'b1, 8'h02, 1'b0, 0, 7'b0000100};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1, 7'b0000010};

    reset = 1'b1;
    mask_bit = 1'b0;
    data = 8'h00;
    fifo_full = 1'b0;
    step();
    step();
    checkOutput("reset outputs", outVec(), 0);
    checkOutput("reset ack", int'(data_ack), 0);
    reset = 1'b0;
    step();

    // Command-level vectors: STOP in CLEAR, unknown opcodes, START in ARM,
    // fifo_full while idle.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), outVec(), int'(vecs[i].expOut));
    end

    // START_TIMED with a zero duration runs untimed.
    sendByte(8'h04);
    repeat (40) step();
    checkOutput("dur0 untimed", int'({running, seq_operate}), 3);
    sendByte(8'h02);
    checkOutput("dur0 halt", int'(stop_det), 1);
    waitDone("dur0 done", 10);

    runTimed(10, "timed10");
    runTimed(1, "timed1");

    // Long untimed run ended by STOP.
    sp0 = stopCnt;
    sendByte(8'h01);
    repeat (100) step();
    checkOutput("long run level", int'({running, seq_operate}), 3);
    checkOutput("long run no stop", stopCnt - sp0, 0);
    sendByte(8'h02);
    checkOutput("long run halt", int'({running, stop_det}), 1);
    waitDone("long run done", 10);
    checkOutput("long run stops", stopCnt - sp0, 1);
    checkOutput("long run seq off", int'(seq_operate), 0);

    // STOP consumed in the same cycle the timer expires.
    sendByte(8'h03);
    sendByte(8'h05);
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h00);
    sp0 = stopCnt; dn0 = doneCnt; rn0 = runCnt;
    sendByte(8'h04);
    repeat (7) step();
    sendByte(8'h02);
    checkOutput("coincident halt", int'(stop_det), 1);
    waitDone("coincident done", 10);
    repeat (3) step();
    checkOutput("coincident run cycles", runCnt - rn0, 5);
    checkOutput("coincident stops", stopCnt - sp0, 1);
    checkOutput("coincident dones", doneCnt - dn0, 1);

    // Overflow flag behaviour.
    sendByte(8'h01);
    repeat (3) step();
    fifo_full = 1'b1;
    step();
    fifo_full = 1'b0;
    checkOutput("ovf set", int'(overflow), 1);
`ifdef ACQ_OVERFLOW_STOP_EN
    checkOutput("ovf stop halt", int'({running, stop_det}), 1);
    waitDone("ovf stop done", 10);
    sendByte(8'h05);
    checkOutput("ovf cleared", int'(overflow), 0);
`else
    checkOutput("ovf keeps running", int'({running, seq_operate, stop_det}), 6);
    repeat (3) step();
    checkOutput("ovf still running", int'(running), 1);
    fifo_full = 1'b1;
    sendByte(8'h05);
    fifo_full = 1'b0;
    checkOutput("ovf clr vs full", int'(overflow), 1);
    sendByte(8'h05);
    checkOutput("ovf cleared", int'(overflow), 0);
    sendByte(8'h02);
    waitDone("ovf run done", 10);
`endif

    // Reset in RUN with a partial SET_DUR pending.
    sendByte(8'h01);
    repeat (5) step();
    sendByte(8'h03);
    sendByte(8'h05);
    step();
    checkOutput("pre-reset running", int'(running), 1);
    sp0 = stopCnt; dn0 = doneCnt;
    reset = 1'b1;
    step();
    checkOutput("reset in run outputs", outVec(), 0);
    checkOutput("reset in run ack", int'(data_ack), 0);
    reset = 1'b0;
    repeat (3) step();
    checkOutput("reset in run no stop", stopCnt - sp0, 0);
    checkOutput("reset in run no done", doneCnt - dn0, 0);
    sendByte(8'h04);
    checkOutput("post-reset start", int'(reset_counter), 1);
    repeat (30) step();
    checkOutput("post-reset untimed", int'(running), 1);
    sendByte(8'h02);
    waitDone("post-reset done", 10);

    checkOutput("ack count", ackCnt, bytesSent);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter DUR_W, default 32: width of acquisition-duration register, in clk cycles.
REQ-002 Parameter CLR_CYCLES, default 2: number of cycles reset_counter is held in CLEAR state, range 1-15.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mask_bit  input  1  command byte available for this block.
REQ-006 data  input  8  command byte, stable while mask_bit high.
REQ-007 data_ack  output  1  one-cycle pulse consuming the current byte.
REQ-008 fifo_full  input  1  sample FIFO write-side full.
REQ-009 reset_counter  output  1  clears timetag counter; high throughout CLEAR.
REQ-010 start_det  output  1  one-cycle pulse starting detection.
REQ-011 stop_det  output  1  one-cycle pulse stopping detection.
REQ-012 seq_operate  output  1  level enabling the laser pulse sequencers.
REQ-013 running  output  1  level, high in CLEAR, ARM and RUN.
REQ-014 overflow  output  1  sticky flag, fifo_full seen while running.
REQ-015 done  output  1  one-cycle pulse on entry to IDLE from HALT.

Function
REQ-016 Byte handshake: while mask_bit is high and the parser is ready, the block SHALL consume data and assert data_ack for exactly one cycle; the next byte is not sampled until mask_bit is high again after the ack cycle.
REQ-017 Opcodes: 0x01 START, 0x02 STOP, 0x03 SET_DUR (followed by DUR_W/8 bytes, LSB first), 0x04 START_TIMED, 0x05 CLR_OVF; any other byte is acked and ignored.
REQ-018 SET_DUR bytes SHALL go to a shadow register; it is copied to the live duration on START_TIMED and is accepted in any state.
REQ-019 States: IDLE, CLEAR, ARM, RUN, HALT.
REQ-020 IDLE->CLEAR on START or START_TIMED; CLEAR lasts CLR_CYCLES cycles with reset_counter=1.
REQ-021 CLEAR->ARM; ARM lasts one cycle with start_det=1 and seq_operate set to 1 on that cycle.
REQ-022 ARM->RUN; in RUN with timed mode, the down-counter is loaded with duration at ARM and decrements each RUN cycle; at 1 -> HALT, giving exactly duration RUN cycles.
REQ-023 START_TIMED with duration 0 SHALL behave as untimed START.
REQ-024 RUN->HALT on STOP byte; HALT lasts one cycle with stop_det=1 and seq_operate cleared on that cycle, then -> IDLE with done=1 for one cycle.
REQ-025 STOP byte and timer expiry in the same cycle SHALL produce a single HALT, a single stop_det pulse and a single done pulse.
REQ-026 START/START_TIMED outside IDLE and STOP outside RUN SHALL be acked and ignored; a STOP received in CLEAR or ARM is not queued.
REQ-027 overflow SET when fifo_full=1 while running=1; cleared only by CLR_OVF or reset; CLR_OVF with simultaneous fifo_full leaves overflow at 1.
REQ-028 Timer counter SHALL not wrap: decrement stops at 0.

Reset
REQ-029 reset=1 SHALL force IDLE; data_ack, reset_counter, start_det, stop_det, seq_operate, running, overflow and done all 0; shadow and live duration = 0; partial SET_DUR sequence discarded.
REQ-030 Reset mid-RUN SHALL emit no stop_det pulse; seq_operate drops on the cycle after reset is sampled.

Configuration
REQ-031 Macro ACQ_OVERFLOW_STOP_EN defined: fifo_full in RUN SHALL force RUN->HALT next cycle, in addition to setting overflow.
REQ-032 Macro undefined: fifo_full only sets overflow; the acquisition continues until STOP or timer expiry.

Verification
REQ-033 Send SET_DUR 0x0A,0,0,0 then START_TIMED -> reset_counter high 2 cycles, start_det 1 pulse, 10 RUN cycles, stop_det pulse, done pulse, running low.
REQ-034 Send START, wait 100 cycles, then STOP -> running stays high until HALT; exactly one stop_det; seq_operate 0 after HALT.
REQ-035 Duration 5, assert STOP on the byte accepted in the last RUN cycle -> exactly one stop_det and one done.
REQ-036 START, pulse fifo_full in RUN -> overflow=1; with ACQ_OVERFLOW_STOP_EN, HALT on the next cycle; without it, running stays 1; CLR_OVF -> overflow=0.
REQ-037 Send START then STOP during CLEAR, plus opcode 0x7F -> all bytes acked, STOP ignored, acquisition proceeds to RUN.
REQ-038 Assert reset in RUN -> next cycle all outputs 0, state IDLE, no stop_det.
